// File: rtl/circle_plotter.sv
// Midpoint circle engine for a 160x120 framebuffer with an optional clear sweep.
// Emits one registered pixel write per clock: eight octant points per iteration,
// then one update cycle. Off-screen points take their cycle but do not plot.
module circle_plotter #(
  parameter int SCR_W    = 160,
  parameter int SCR_H    = 120,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [6:0] radius,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_OCT, S_UPDATE, S_DONE} state_t;

  localparam logic signed [9:0] W_S        = 10'(SCR_W);
  localparam logic signed [9:0] H_S        = 10'(SCR_H);
  localparam logic [7:0]        CLR_X_LAST = 8'(SCR_W - 1);
  localparam logic [6:0]        CLR_Y_LAST = 7'(SCR_H - 1);

  state_t            state_q, state_d;
  logic [2:0]        oct_q, oct_d;      // 0..7 encodes octant 1..8
  logic [7:0]        cx_q, cx_d;
  logic [6:0]        cy_q, cy_d;
  logic [2:0]        col_q, col_d;
  logic [6:0]        ox_q, ox_d, oy_q, oy_d;
  logic signed [9:0] crit_q, crit_d;
  logic [7:0]        clr_x_q, clr_x_d;
  logic [6:0]        clr_y_q, clr_y_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic [2:0]        colour_q, colour_d;
  logic              plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  // Signed working values; 10 bits so centre+offset never wraps before the clip test.
  logic signed [9:0] cx_s, cy_s, ox_s, oy_s, cand_x, cand_y;
  logic signed [9:0] oy_n, ox_n, delta;
  logic              on_scr;

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

  // Candidate point for the current octant and its on-screen test.
  always_comb begin
    cx_s = $signed({2'b00, cx_q});
    cy_s = $signed({3'b000, cy_q});
    ox_s = $signed({3'b000, ox_q});
    oy_s = $signed({3'b000, oy_q});
    case (oct_q)
      3'd0:    begin cand_x = cx_s + ox_s; cand_y = cy_s + oy_s; end
      3'd1:    begin cand_x = cx_s + oy_s; cand_y = cy_s + ox_s; end
      3'd2:    begin cand_x = cx_s - oy_s; cand_y = cy_s + ox_s; end
      3'd3:    begin cand_x = cx_s - ox_s; cand_y = cy_s + oy_s; end
      3'd4:    begin cand_x = cx_s - ox_s; cand_y = cy_s - oy_s; end
      3'd5:    begin cand_x = cx_s - oy_s; cand_y = cy_s - ox_s; end
      3'd6:    begin cand_x = cx_s + oy_s; cand_y = cy_s - ox_s; end
      default: begin cand_x = cx_s + ox_s; cand_y = cy_s - oy_s; end
    endcase
    on_scr = (cand_x >= 10'sd0) && (cand_x < W_S) && (cand_y >= 10'sd0) && (cand_y < H_S);
  end

  // State, working registers and registered pixel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      oct_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      col_q    <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      crit_q   <= '0;
      clr_x_q  <= '0;
      clr_y_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      oct_q    <= oct_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      col_q    <= col_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      crit_q   <= crit_d;
      clr_x_q  <= clr_x_d;
      clr_y_q  <= clr_y_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic; outputs reflect the state being left.
  always_comb begin
    state_d  = state_q;
    oct_d    = oct_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    col_d    = col_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    crit_d   = crit_q;
    clr_x_d  = clr_x_q;
    clr_y_d  = clr_y_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    oy_n     = oy_s + 10'sd1;
    ox_n     = ox_s;
    delta    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d    = centre_x;
          cy_d    = centre_y;
          col_d   = colour_in;
          ox_d    = radius;
          oy_d    = '0;
          crit_d  = 10'sd1 - $signed({3'b000, radius});
          oct_d   = '0;
          clr_x_d = '0;
          clr_y_d = '0;
          busy_d  = 1'b1;
          state_d = CLEAR_EN ? S_CLEAR : S_OCT;
        end
      end
      S_CLEAR: begin
        busy_d   = 1'b1;
        plot_d   = 1'b1;
        x_d      = clr_x_q;
        y_d      = clr_y_q;
        colour_d = '0;
        if (clr_x_q == CLR_X_LAST) begin
          clr_x_d = '0;
          if (clr_y_q == CLR_Y_LAST) begin
            clr_y_d = '0;
            state_d = S_OCT;
          end else begin
            clr_y_d = clr_y_q + 7'd1;
          end
        end else begin
          clr_x_d = clr_x_q + 8'd1;
        end
      end
      S_OCT: begin
        busy_d   = 1'b1;
        x_d      = cand_x[7:0];
        y_d      = cand_y[6:0];
        colour_d = col_q;
        plot_d   = on_scr;
        oct_d    = oct_q + 3'd1;
        if (oct_q == 3'd7) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        busy_d = 1'b1;
        oy_d   = oy_n[6:0];
        oct_d  = '0;
        if (crit_q <= 10'sd0) begin
          crit_d = crit_q + $signed({oy_n[8:0], 1'b0}) + 10'sd1;
        end else begin
          // ox may step to -1 (radius 0); the signed compare below still ends the draw.
          ox_n   = ox_s - 10'sd1;
          ox_d   = ox_n[6:0];
          delta  = oy_n - ox_n;
          crit_d = crit_q + $signed({delta[8:0], 1'b0}) + 10'sd1;
        end
        state_d = (oy_n > ox_n) ? S_DONE : S_OCT;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_circle_plotter.sv
// Directed bench: one instance without clear (most scenarios), one with clear.
module tb_circle_plotter;
  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start1;
  logic [7:0] cx0, cx1;
  logic [6:0] cy0, cy1, r0, r1;
  logic [2:0] col0, col1;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [2:0] colour0, colour1;
  logic       plot0, plot1, busy0, busy1, done0, done1;

  int errors = 0;
  int checks = 0;

  circle_plotter #(.SCR_W(160), .SCR_H(120), .CLEAR_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .centre_x(cx0), .centre_y(cy0),
    .radius(r0), .colour_in(col0), .x(x0), .y(y0), .colour(colour0),
    .plot(plot0), .busy(busy0), .done(done0));

  circle_plotter #(.SCR_W(160), .SCR_H(120), .CLEAR_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .centre_x(cx1), .centre_y(cy1),
    .radius(r1), .colour_in(col1), .x(x1), .y(y1), .colour(colour1),
    .plot(plot1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start to dut0; returns 1 time unit after the accepting edge.
  task automatic go0(input logic [7:0] cx, input logic [6:0] cy, input logic [6:0] r,
                     input logic [2:0] col);
    @(negedge clk);
    cx0 = cx; cy0 = cy; r0 = r; col0 = col; start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  // Radius 1 at (80,60); optionally pulses a conflicting start mid-draw.
  task automatic run_r1(input logic [2:0] col, input bit inject, input string tg);
    int nplot, first, dcyc;
    nplot = 0; first = -1; dcyc = -1;
    go0(8'd80, 7'd60, 7'd1, col);
    for (int c = 1; c <= 25; c++) begin
      if (inject && c == 3) begin
        cx0 = 8'd10; cy0 = 7'd5; r0 = 7'd5; col0 = 3'd7; start0 = 1'b1;
      end
      if (inject && c == 5) start0 = 1'b0;
      tick();
      if (plot0) begin nplot++; if (first < 0) first = c; end
      if (done0) dcyc = c;
      if (c == 1)  begin chk({tg, "_o1"}, {x0, y0}, {8'd81, 7'd60}); chk({tg, "_col1"}, colour0, col); end
      if (c == 2)  chk({tg, "_o2"}, {x0, y0}, {8'd80, 7'd61});
      if (c == 5)  chk({tg, "_o5"}, {x0, y0}, {8'd79, 7'd60});
      if (c == 10) begin chk({tg, "_i2o1"}, {x0, y0}, {8'd81, 7'd61}); chk({tg, "_col10"}, colour0, col); end
      if (c == 15) chk({tg, "_i2o6"}, {x0, y0}, {8'd79, 7'd59});
    end
    chk({tg, "_nplot"}, nplot, 16);
    chk({tg, "_first"}, first, 1);
    chk({tg, "_done_cyc"}, dcyc, 19);
    chk({tg, "_idle_busy"}, busy0, 1'b0);
  endtask

  initial begin
    int dseen, bad, cnt;
    logic [7:0] pat;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    cx0 = '0; cy0 = '0; r0 = '0; col0 = '0;
    cx1 = '0; cy1 = '0; r1 = '0; col1 = '0;
    #1;
    chk("rst_out0", {x0, y0, colour0, plot0, busy0, done0}, '0);
    chk("rst_out1", {x1, y1, colour1, plot1, busy1, done1}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Radius 0: eight plots of the centre, an update, then done on cycle 10.
    go0(8'd80, 7'd60, 7'd0, 3'd5);
    chk("r0_busy", busy0, 1'b1);
    chk("r0_plot0", plot0, 1'b0);
    cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (plot0 && x0 == 8'd80 && y0 == 7'd60 && colour0 == 3'd5) cnt++;
    end
    chk("r0_centre_plots", cnt, 8);
    tick();
    chk("r0_update", {plot0, busy0, done0}, 3'b010);
    tick();
    chk("r0_done", {plot0, busy0, done0}, 3'b001);
    tick();
    chk("r0_after", done0, 1'b0);

    run_r1(3'd3, 1'b0, "r1");
    run_r1(3'd2, 1'b1, "ignore_start");

    // Clipping at the top-left corner.
    go0(8'd0, 7'd0, 7'd10, 3'd2);
    dseen = 0; bad = 0; pat = '0;
    for (int c = 1; c <= 300 && dseen == 0; c++) begin
      tick();
      if (c <= 8) pat[c-1] = plot0;
      if (c == 1) chk("clip_o1", {x0, y0}, {8'd10, 7'd0});
      if (c == 2) chk("clip_o2", {x0, y0}, {8'd0, 7'd10});
      if (c == 3) chk("clip_o3", {x0, y0}, {8'd0, 7'd10});
      if (c == 8) chk("clip_o8", {x0, y0}, {8'd10, 7'd0});
      if (plot0 && (x0 >= 8'd160 || y0 >= 7'd120)) bad++;
      if (done0) dseen = 1;
    end
    chk("clip_pattern", pat, 8'b1000_0111);
    chk("clip_offscreen", bad, 0);
    chk("clip_done_seen", dseen, 1);

    // Asynchronous reset while drawing radius 50.
    go0(8'd80, 7'd60, 7'd50, 3'd6);
    repeat (5) tick();
    chk("mid_oct5", {plot0, x0, y0}, {1'b1, 8'd30, 7'd60});
    reset = 1'b1;
    #1;
    chk("async_rst", {x0, y0, colour0, plot0, busy0, done0}, '0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy0 || done0 || plot0) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);
    run_r1(3'd4, 1'b0, "after_rst");

    // Clear sweep ahead of the circle.
    @(negedge clk);
    cx1 = 8'd80; cy1 = 7'd60; r1 = 7'd1; col1 = 3'd7; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    bad = 0;
    for (int i = 0; i < 19200; i++) begin
      tick();
      if (!(plot1 && colour1 == 3'd0 && x1 == 8'(i % 160) && y1 == 7'(i / 160))) bad++;
      if (i == 0)     chk("clr_first", {plot1, x1, y1}, {1'b1, 8'd0, 7'd0});
      if (i == 1)     chk("clr_second", {plot1, x1, y1}, {1'b1, 8'd1, 7'd0});
      if (i == 19199) chk("clr_last", {plot1, x1, y1}, {1'b1, 8'd159, 7'd119});
    end
    chk("clr_sweep", bad, 0);
    tick();
    chk("clr_circle_o1", {plot1, x1, y1, colour1}, {1'b1, 8'd81, 7'd60, 3'd7});
    dseen = -1;
    for (int c = 2; c <= 25; c++) begin
      tick();
      if (done1) dseen = c;
    end
    chk("clr_done_cyc", dseen, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
